// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - select/strobe and sample bus between mux_scan_ctrl and its user
//
// Purpose: bundles the scan request, the 153-style mux select/strobe/data
// lines and the recovered-word outputs into one port.
// Signals:
//   i_start  one-cycle scan request (ignored while o_busy=1)
//   i_cont   continuous-scan enable, sampled at end of frame
//   i_1Y     section-1 mux output
//   i_2Y     section-2 mux output
//   o_B/o_A  select code to the mux (MSB/LSB)
//   o_G      active-low strobe to both mux sections
//   o_1C     recovered section-1 inputs, bit n = channel n
//   o_2C     recovered section-2 inputs, bit n = channel n
//   o_busy   frame in progress
//   o_done   one-cycle pulse after o_1C/o_2C update
// Modports: slave = scanner side, master = user/mux side.

interface mux_scan_ctrl_if;
  logic       i_start;
  logic       i_cont;
  logic       i_1Y;
  logic       i_2Y;
  logic       o_B;
  logic       o_A;
  logic       o_G;
  logic [3:0] o_1C;
  logic [3:0] o_2C;
  logic       o_busy;
  logic       o_done;

  modport slave (
    input  i_start, i_cont, i_1Y, i_2Y,
    output o_B, o_A, o_G, o_1C, o_2C, o_busy, o_done
  );

  modport master (
    output i_start, i_cont, i_1Y, i_2Y,
    input  o_B, o_A, o_G, o_1C, o_2C, o_busy, o_done
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sequential scanner for a dual 4-to-1 data selector
//
// Purpose: steps the select code of a 153-class dual mux through channels
// 0..3, holds each code for SETTLE cycles, samples both mux outputs at the
// last cycle of each window and publishes the two recovered 4-bit words
// together at the end of the frame. Single-shot or continuous.
// Parameters:
//   SETTLE   cycles each select code is held before sampling (1..15)
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   bus      mux_scan_ctrl_if.slave (request, mux lines, recovered words)

module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mux_scan_ctrl_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  // Settle counter value at which the current slot is sampled.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [0:0] state_q,  state_d;
  logic [1:0] slot_q,   slot_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] sh1_q,    sh1_d;
  logic [2:0] sh2_q,    sh2_d;
  logic [3:0] c1_q,     c1_d;
  logic [3:0] c2_q,     c2_d;
  logic       done_q,   done_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    settle_d = settle_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        slot_d   = 2'd0;
        settle_d = 4'd0;
        if (bus.i_start) begin
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 4'd0;
          case (slot_q)
            2'd0: begin
              sh1_d[0] = bus.i_1Y;
              sh2_d[0] = bus.i_2Y;
              slot_d   = 2'd1;
            end
            2'd1: begin
              sh1_d[1] = bus.i_1Y;
              sh2_d[1] = bus.i_2Y;
              slot_d   = 2'd2;
            end
            2'd2: begin
              sh1_d[2] = bus.i_1Y;
              sh2_d[2] = bus.i_2Y;
              slot_d   = 2'd3;
            end
            default: begin
              // Last channel goes straight into the output word so both
              // words switch from old frame to new frame on one edge.
              c1_d   = {bus.i_1Y, sh1_q};
              c2_d   = {bus.i_2Y, sh2_q};
              done_d = 1'b1;
              slot_d = 2'd0;
              if (!bus.i_cont) begin
                state_d = S_IDLE;
              end
            end
          endcase
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      slot_q   <= 2'd0;
      settle_q <= 4'd0;
      sh1_q    <= 3'd0;
      sh2_q    <= 3'd0;
      c1_q     <= 4'd0;
      c2_q     <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      settle_q <= settle_d;
      sh1_q    <= sh1_d;
      sh2_q    <= sh2_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      done_q   <= done_d;
    end
  end

  // Select and strobe come straight off flops; slot is held at 0 in IDLE.
  assign bus.o_B    = slot_q[1];
  assign bus.o_A    = slot_q[0];
  assign bus.o_G    = (state_q == S_IDLE);
  assign bus.o_busy = (state_q == S_SCAN);
  assign bus.o_1C   = c1_q;
  assign bus.o_2C   = c2_q;
  assign bus.o_done = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl with SETTLE 2, 1 and 15

module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_scan_ctrl_if if_a ();
  mux_scan_ctrl_if if_b ();
  mux_scan_ctrl_if if_c ();

  mux_scan_ctrl #(.SETTLE(2))  dut_a (.i_clk(clk), .i_rst(rst), .bus(if_a.slave));
  mux_scan_ctrl #(.SETTLE(1))  dut_b (.i_clk(clk), .i_rst(rst), .bus(if_b.slave));
  mux_scan_ctrl #(.SETTLE(15)) dut_c (.i_clk(clk), .i_rst(rst), .bus(if_c.slave));

  // Behavioural dual 4-to-1 mux: the channel inputs, selected by each DUT.
  logic [3:0] c1;
  logic [3:0] c2;
  assign if_a.i_1Y = c1[{if_a.o_B, if_a.o_A}];
  assign if_a.i_2Y = c2[{if_a.o_B, if_a.o_A}];
  assign if_b.i_1Y = c1[{if_b.o_B, if_b.o_A}];
  assign if_b.i_2Y = c2[{if_b.o_B, if_b.o_A}];
  assign if_c.i_1Y = c1[{if_c.o_B, if_c.o_A}];
  assign if_c.i_2Y = c2[{if_c.o_B, if_c.o_A}];

  int checks   = 0;
  int failures = 0;

  // Channel contents present at every rising edge, indexed by edge number.
  int         cyc = 0;
  logic [3:0] h1 [0:4095];
  logic [3:0] h2 [0:4095];
  always @(posedge clk) begin
    if (cyc < 4096) begin
      h1[cyc] = c1;
      h2[cyc] = c2;
    end
    cyc = cyc + 1;
  end

  // Last published words per DUT.
  logic [3:0] lw1 [3];
  logic [3:0] lw2 [3];

  function automatic int stl(input int w);
    case (w)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [12:0] obs(input int w);
    case (w)
      0:       return {if_a.o_busy, if_a.o_G, if_a.o_B, if_a.o_A, if_a.o_done, if_a.o_1C, if_a.o_2C};
      1:       return {if_b.o_busy, if_b.o_G, if_b.o_B, if_b.o_A, if_b.o_done, if_b.o_1C, if_b.o_2C};
      default: return {if_c.o_busy, if_c.o_G, if_c.o_B, if_c.o_A, if_c.o_done, if_c.o_1C, if_c.o_2C};
    endcase
  endfunction

  function automatic logic [12:0] pk(input logic busy, input logic g, input logic [1:0] sel,
                                     input logic done, input logic [3:0] w1, input logic [3:0] w2);
    return {busy, g, sel, done, w1, w2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       if_a.i_start = v;
      1:       if_b.i_start = v;
      default: if_c.i_start = v;
    endcase
  endtask

  task automatic set_cont(input int w, input logic v);
    case (w)
      0:       if_a.i_cont = v;
      1:       if_b.i_cont = v;
      default: if_c.i_cont = v;
    endcase
  endtask

  // Raise i_start for one edge; k returns the index of the edge that sees it.
  task automatic pulse(input int w, output int k);
    set_start(w, 1'b1);
    k = cyc;
    @(negedge clk);
  endtask

  // Entered at the negedge after edge k (the start or previous end-of-frame
  // edge). Checks every cycle of the frame; expected words come from the
  // channel contents at edge k+(n+1)*SETTLE for channel n.
  task automatic check_frame(input int w, input int k, input bit prev_done, input bit cont_after,
                             input bit rnd, input bit extra, input int chg_t, input logic [3:0] chg1,
                             output logic [3:0] r1, output logic [3:0] r2);
    int s = stl(w);
    r1 = 4'd0;
    r2 = 4'd0;
    for (int t = 0; t <= 4 * s; t++) begin
      if (t < 4 * s) begin
        chk($sformatf("frame_w%0d_t%0d", w, t), 32'(obs(w)),
            32'(pk(1'b1, 1'b0, 2'(t / s), (t == 0) ? prev_done : 1'b0, lw1[w], lw2[w])));
      end else begin
        for (int n = 0; n < 4; n++) begin
          r1[n] = h1[k + (n + 1) * s][n];
          r2[n] = h2[k + (n + 1) * s][n];
        end
        chk($sformatf("frame_end_w%0d", w), 32'(obs(w)),
            32'(pk(cont_after, !cont_after, 2'd0, 1'b1, r1, r2)));
        lw1[w] = r1;
        lw2[w] = r2;
      end
      set_start(w, extra && (t == 2 || t == 4));
      if (t >= 1) set_cont(w, cont_after);
      if (rnd) begin
        c1 = 4'($urandom);
        c2 = 4'($urandom);
      end
      if (t == chg_t) c1 = chg1;
      if (t < 4 * s) @(negedge clk);
    end
    if (!cont_after) begin
      @(negedge clk);
      chk($sformatf("post_idle_w%0d", w), 32'(obs(w)),
          32'(pk(1'b0, 1'b1, 2'd0, 1'b0, lw1[w], lw2[w])));
    end
  endtask

  initial begin
    int k;
    logic [3:0] r1, r2;

    rst = 1'b1;
    c1  = 4'd0;
    c2  = 4'd0;
    for (int w = 0; w < 3; w++) begin
      set_start(w, 1'b0);
      set_cont(w, 1'b0);
      lw1[w] = 4'd0;
      lw2[w] = 4'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 3; w++)
      chk($sformatf("reset_w%0d", w), 32'(obs(w)), 32'(pk(1'b0, 1'b1, 2'd0, 1'b0, 4'd0, 4'd0)));

    // Abort after the slot-2 sample edge with an asynchronous mid-cycle reset.
    c1 = 4'b1010;
    c2 = 4'b0110;
    pulse(0, k);
    set_start(0, 1'b0);
    repeat (6) @(negedge clk);
    chk("abort_pre_busy", 32'(obs(0)), 32'(pk(1'b1, 1'b0, 2'd3, 1'b0, 4'd0, 4'd0)));
    #2 rst = 1'b1;
    #1 chk("async_reset", 32'(obs(0)), 32'(pk(1'b0, 1'b1, 2'd0, 1'b0, 4'd0, 4'd0)));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("reset_hold_%0d", i), 32'(obs(0)), 32'(pk(1'b0, 1'b1, 2'd0, 1'b0, 4'd0, 4'd0)));
    end

    // Single scan, SETTLE=2.
    pulse(0, k);
    check_frame(0, k, 1'b0, 1'b0, 1'b0, 1'b0, -1, 4'd0, r1, r2);
    chk("single_1C", 32'(r1), 32'(4'b1010));
    chk("single_2C", 32'(r2), 32'(4'b0110));

    // Start requests during a frame are ignored.
    c1 = 4'b0011;
    c2 = 4'b1100;
    pulse(0, k);
    check_frame(0, k, 1'b0, 1'b0, 1'b0, 1'b1, -1, 4'd0, r1, r2);
    chk("ignored_start_1C", 32'(r1), 32'(4'b0011));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("no_extra_frame_%0d", i), 32'({obs(0)[12], obs(0)[8]}), 32'(2'b00));
    end

    // Continuous: change section-1 inputs mid-frame, then drop i_cont.
    c1 = 4'b1010;
    c2 = 4'b0110;
    set_cont(0, 1'b1);
    pulse(0, k);
    check_frame(0, k, 1'b0, 1'b1, 1'b0, 1'b0, 3, 4'b0101, r1, r2);
    chk("cont_f1_1C", 32'(r1), 32'(4'b0100));
    chk("cont_f1_2C", 32'(r2), 32'(4'b0110));
    check_frame(0, k + 8, 1'b1, 1'b1, 1'b0, 1'b0, -1, 4'd0, r1, r2);
    chk("cont_f2_1C", 32'(r1), 32'(4'b0101));
    check_frame(0, k + 16, 1'b1, 1'b0, 1'b0, 1'b0, -1, 4'd0, r1, r2);
    chk("cont_f3_1C", 32'(r1), 32'(4'b0101));

    // SETTLE=1: random inputs changing every cycle.
    for (int i = 0; i < 4; i++) begin
      c1 = 4'($urandom);
      c2 = 4'($urandom);
      pulse(1, k);
      check_frame(1, k, 1'b0, 1'b0, 1'b1, 1'b0, -1, 4'd0, r1, r2);
    end

    // SETTLE=1 continuous with random inputs.
    set_cont(1, 1'b1);
    pulse(1, k);
    check_frame(1, k, 1'b0, 1'b1, 1'b1, 1'b0, -1, 4'd0, r1, r2);
    check_frame(1, k + 4, 1'b1, 1'b1, 1'b1, 1'b0, -1, 4'd0, r1, r2);
    check_frame(1, k + 8, 1'b1, 1'b0, 1'b1, 1'b0, -1, 4'd0, r1, r2);

    // SETTLE=15: toggles inside each settle window must not be captured.
    for (int i = 0; i < 2; i++) begin
      c1 = 4'($urandom);
      c2 = 4'($urandom);
      pulse(2, k);
      check_frame(2, k, 1'b0, 1'b0, 1'b1, 1'b0, -1, 4'd0, r1, r2);
    end

    // SETTLE=2 random single shots.
    for (int i = 0; i < 3; i++) begin
      c1 = 4'($urandom);
      c2 = 4'($urandom);
      pulse(0, k);
      check_frame(0, k, 1'b0, 1'b0, 1'b1, 1'b0, -1, 4'd0, r1, r2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
